// File: rtl/cpu_types_pkg.sv
// Shared datapath types, plus the branch predictor's counter type and defaults.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int BP_MAX_CTR_W = 4;
    typedef logic [BP_MAX_CTR_W-1:0] bp_ctr_t;

    localparam int BP_DEFAULT_ENTRIES = 16;
    localparam int BP_DEFAULT_CTR_W   = 2;

    function automatic word_t seqPc(input word_t p);
        return p + 32'd4;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Bundle of the predictor's fetch-side and execute-side signals; CLK/nRST stay module ports.
interface branch_predictor_if;
    import cpu_types_pkg::*;

    word_t pc;
    logic  pred_hit;
    logic  pred_taken;
    word_t pred_target;
    logic  upd_valid;
    word_t upd_pc;
    logic  upd_taken;
    word_t upd_target;
    logic  upd_mispredict;
    logic  flush_tbl;
    word_t mispredict_cnt;

    modport bp (
        input  pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush_tbl,
        output pred_hit, pred_taken, pred_target, mispredict_cnt
    );

    modport fetch (
        output pc,
        input  pred_hit, pred_taken, pred_target
    );

    modport exec (
        output upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush_tbl
    );

endinterface

// File: rtl/sat_counter.sv
// W-bit up/down counter step that sticks at all-ones going up and at zero going down.
module sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] cur,
    input  logic         inc,
    output logic [W-1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (inc && (cur != {W{1'b1}})) begin
            nxt = cur + 1'b1;
        end else if (!inc && (cur != '0)) begin
            nxt = cur - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters; combinational
// lookup for fetch, edge-triggered update from execute.
module branch_predictor
    import cpu_types_pkg::*;
#(
    parameter int ENTRIES = BP_DEFAULT_ENTRIES,
    parameter int CTR_W   = BP_DEFAULT_CTR_W,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 32 - IDX_W - 2
) (
    input  logic  CLK,
    input  logic  nRST,
    input  word_t pc,
    output logic  pred_hit,
    output logic  pred_taken,
    output word_t pred_target,
    input  logic  upd_valid,
    input  word_t upd_pc,
    input  logic  upd_taken,
    input  word_t upd_target,
    input  logic  upd_mispredict,
    input  logic  flush_tbl,
    output word_t mispredict_cnt
);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        word_t            target;
        logic [CTR_W-1:0] ctr;
    } entry_t;

    entry_t entryTable_q [ENTRIES];
    entry_t lookEntry;
    entry_t updEntry;
    entry_t entry_d;
    logic   writeEn;

    logic [IDX_W-1:0] lookIdx;
    logic [IDX_W-1:0] updIdx;
    logic [TAG_W-1:0] lookTag;
    logic [TAG_W-1:0] updTag;
    logic             updHit;
    logic [CTR_W-1:0] ctrNext;

    word_t mispredictCnt_q;
    word_t mispredictCnt_d;

    logic unusedUpdPcLow;
    assign unusedUpdPcLow = ^upd_pc[1:0];

    assign lookIdx   = pc[IDX_W+1:2];
    assign lookTag   = pc[31:IDX_W+2];
    assign updIdx    = upd_pc[IDX_W+1:2];
    assign updTag    = upd_pc[31:IDX_W+2];
    assign lookEntry = entryTable_q[lookIdx];
    assign updEntry  = entryTable_q[updIdx];
    assign updHit    = updEntry.valid && (updEntry.tag == updTag);

    // Lookup reads only registered table state, so a same-cycle update is not bypassed.
    always_comb begin
        pred_hit    = lookEntry.valid && (lookEntry.tag == lookTag);
        pred_taken  = pred_hit && lookEntry.ctr[CTR_W-1];
        pred_target = pred_taken ? lookEntry.target : seqPc(pc);
    end

    sat_counter #(
        .W (CTR_W)
    ) u_updCtr (
        .cur (updEntry.ctr),
        .inc (upd_taken),
        .nxt (ctrNext)
    );

    always_comb begin
        entry_d = updEntry;
        writeEn = 1'b0;
        if (upd_valid) begin
            if (updHit) begin
                writeEn     = 1'b1;
                entry_d.ctr = ctrNext;
                if (upd_taken) begin
                    entry_d.target = upd_target;
                end
            end else if (upd_taken) begin
                // New entries start weakly taken: MSB set, lower bits clear.
                writeEn              = 1'b1;
                entry_d.valid        = 1'b1;
                entry_d.tag          = updTag;
                entry_d.target       = upd_target;
                entry_d.ctr          = '0;
                entry_d.ctr[CTR_W-1] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entryTable_q[i] <= '0;
            end
        end else if (flush_tbl) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entryTable_q[i].valid <= 1'b0;
            end
        end else if (writeEn) begin
            entryTable_q[updIdx] <= entry_d;
        end
    end

    // Mispredicts are counted even when a flush discards the accompanying update.
    always_comb begin
        mispredictCnt_d = mispredictCnt_q;
        if (upd_valid && upd_mispredict && (mispredictCnt_q != 32'hFFFF_FFFF)) begin
            mispredictCnt_d = mispredictCnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mispredictCnt_q <= '0;
        end else begin
            mispredictCnt_q <= mispredictCnt_d;
        end
    end

    assign mispredict_cnt = mispredictCnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor at 16x2-bit and 4x1-bit configurations.
module tb_branch_predictor;
    import cpu_types_pkg::*;

    logic  CLK;
    logic  nRST;

    word_t aPc, aTarget, aUpdPc, aUpdTarget, aCnt;
    logic  aHit, aTaken, aUpdValid, aUpdTaken, aUpdMisp, aFlush;
    word_t bPc, bTarget, bUpdPc, bUpdTarget, bCnt;
    logic  bHit, bTaken, bUpdValid, bUpdTaken, bUpdMisp, bFlush;

    typedef struct {
        int    sel;
        int    kind;
        word_t value;
    } exp_t;

    exp_t  expQ [$];
    string nameQ [$];
    int    vectors = 0;
    int    miscompares = 0;

    branch_predictor #(.ENTRIES(16), .CTR_W(2)) dut_a (
        .CLK (CLK), .nRST (nRST), .pc (aPc),
        .pred_hit (aHit), .pred_taken (aTaken), .pred_target (aTarget),
        .upd_valid (aUpdValid), .upd_pc (aUpdPc), .upd_taken (aUpdTaken),
        .upd_target (aUpdTarget), .upd_mispredict (aUpdMisp),
        .flush_tbl (aFlush), .mispredict_cnt (aCnt)
    );

    branch_predictor #(.ENTRIES(4), .CTR_W(1)) dut_b (
        .CLK (CLK), .nRST (nRST), .pc (bPc),
        .pred_hit (bHit), .pred_taken (bTaken), .pred_target (bTarget),
        .upd_valid (bUpdValid), .upd_pc (bUpdPc), .upd_taken (bUpdTaken),
        .upd_target (bUpdTarget), .upd_mispredict (bUpdMisp),
        .flush_tbl (bFlush), .mispredict_cnt (bCnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic word_t observed(input int sel, input int kind);
        case (kind)
            0:       return {31'b0, (sel == 0) ? aHit : bHit};
            1:       return {31'b0, (sel == 0) ? aTaken : bTaken};
            2:       return (sel == 0) ? aTarget : bTarget;
            default: return (sel == 0) ? aCnt : bCnt;
        endcase
    endfunction

    task automatic pushExp(input int sel, input int kind, input string name, input word_t value);
        exp_t e;
        e.sel = sel;
        e.kind = kind;
        e.value = value;
        expQ.push_back(e);
        nameQ.push_back(name);
    endtask

    task automatic expectLookup(input int sel, input string name, input logic hit,
                                input logic taken, input word_t tgt);
        pushExp(sel, 0, {name, ".hit"}, {31'b0, hit});
        pushExp(sel, 1, {name, ".taken"}, {31'b0, taken});
        pushExp(sel, 2, {name, ".target"}, tgt);
    endtask

    task automatic expectCnt(input int sel, input string name, input word_t cnt);
        pushExp(sel, 3, {name, ".cnt"}, cnt);
    endtask

    task automatic checkOutput();
        exp_t  e;
        string nm;
        word_t obs;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            nm = nameQ.pop_front();
            obs = observed(e.sel, e.kind);
            vectors++;
            assert (obs === e.value) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed %h expected %h", nm, obs, e.value);
            end
        end
    endtask

    task automatic applyStimulus(input int sel, input word_t lookPc, input logic uv,
                                 input word_t upc, input logic ut, input word_t utgt,
                                 input logic um, input logic fl);
        if (sel == 0) begin
            aPc = lookPc; aUpdValid = uv; aUpdPc = upc; aUpdTaken = ut;
            aUpdTarget = utgt; aUpdMisp = um; aFlush = fl;
        end else begin
            bPc = lookPc; bUpdValid = uv; bUpdPc = upc; bUpdTaken = ut;
            bUpdTarget = utgt; bUpdMisp = um; bFlush = fl;
        end
    endtask

    task automatic idle(input int sel, input word_t lookPc);
        applyStimulus(sel, lookPc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin : stimulus
        word_t satExp [3];
        satExp[0] = 32'hFFFF_FFFE;
        satExp[1] = 32'hFFFF_FFFF;
        satExp[2] = 32'hFFFF_FFFF;

        nRST = 1'b0;
        idle(0, 32'h40);
        idle(1, 32'h40);
        #2;
        expectLookup(0, "reset_a", 1'b0, 1'b0, 32'h44);
        expectCnt(0, "reset_a", 32'h0);
        expectLookup(1, "reset_b", 1'b0, 1'b0, 32'h44);
        expectCnt(1, "reset_b", 32'h0);
        checkOutput();

        // Allocate on both configurations
        @(negedge CLK);
        nRST = 1'b1;
        applyStimulus(0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0);
        applyStimulus(1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0);
        tick();
        idle(0, 32'h40);
        idle(1, 32'h40);
        #1;
        expectLookup(0, "alloc_a", 1'b1, 1'b1, 32'h100);
        expectCnt(0, "alloc_a", 32'h1);
        expectLookup(1, "alloc_b", 1'b1, 1'b1, 32'h100);
        expectCnt(1, "alloc_b", 32'h1);
        checkOutput();
        idle(0, 32'h80);
        idle(1, 32'h80);
        #1;
        expectLookup(0, "alias_a", 1'b0, 1'b0, 32'h84);
        expectLookup(1, "alias_b", 1'b0, 1'b0, 32'h84);
        checkOutput();

        // Saturation and hysteresis on the 2-bit table
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        idle(0, 32'h40);
        #1;
        expectLookup(0, "nt1", 1'b1, 1'b1, 32'h100);
        checkOutput();
        applyStimulus(0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        idle(0, 32'h40);
        #1;
        expectLookup(0, "nt2", 1'b1, 1'b0, 32'h44);
        checkOutput();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
            tick();
        end
        idle(0, 32'h40);
        #1;
        expectLookup(0, "nt_floor", 1'b1, 1'b0, 32'h44);
        checkOutput();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 1'b0);
            tick();
        end
        idle(0, 32'h40);
        #1;
        expectLookup(0, "retrain", 1'b1, 1'b1, 32'h200);
        expectCnt(0, "retrain", 32'h1);
        checkOutput();

        // Same-cycle lookup and update: old contents visible until the edge
        applyStimulus(0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        expectLookup(0, "hazard_same", 1'b1, 1'b1, 32'h200);
        checkOutput();
        tick();
        idle(0, 32'h40);
        #1;
        expectLookup(0, "hazard_next", 1'b1, 1'b0, 32'h44);
        expectCnt(0, "hazard_next", 32'h2);
        checkOutput();
        applyStimulus(0, 32'h44, 1'b1, 32'h44, 1'b1, 32'h300, 1'b1, 1'b0);
        #1;
        expectLookup(0, "alloc_hazard_same", 1'b0, 1'b0, 32'h48);
        checkOutput();
        tick();
        idle(0, 32'h44);
        #1;
        expectLookup(0, "alloc_hazard_next", 1'b1, 1'b1, 32'h300);
        expectCnt(0, "alloc_hazard_next", 32'h3);
        checkOutput();

        // Flush beats a same-cycle allocation; its mispredict still counts
        applyStimulus(0, 32'h40, 1'b1, 32'h48, 1'b1, 32'h400, 1'b1, 1'b1);
        tick();
        idle(0, 32'h40);
        #1;
        expectLookup(0, "flush_40", 1'b0, 1'b0, 32'h44);
        expectCnt(0, "flush", 32'h4);
        checkOutput();
        idle(0, 32'h44);
        #1;
        expectLookup(0, "flush_44", 1'b0, 1'b0, 32'h48);
        checkOutput();
        idle(0, 32'h48);
        #1;
        expectLookup(0, "flush_48", 1'b0, 1'b0, 32'h4C);
        checkOutput();

        // 1-bit table: last-outcome behaviour with holding at both ends
        applyStimulus(1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        idle(1, 32'h40);
        #1;
        expectLookup(1, "b_nt", 1'b1, 1'b0, 32'h44);
        expectCnt(1, "b_nt", 32'h2);
        checkOutput();
        applyStimulus(1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        idle(1, 32'h40);
        #1;
        expectLookup(1, "b_nt_hold", 1'b1, 1'b0, 32'h44);
        checkOutput();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h120, 1'b0, 1'b0);
            tick();
            idle(1, 32'h40);
            #1;
            expectLookup(1, (i == 0) ? "b_t" : "b_t_hold", 1'b1, 1'b1, 32'h120);
            checkOutput();
        end

        // Mispredict counter saturation
        @(negedge CLK);
        force dut_a.mispredictCnt_q = 32'hFFFF_FFFD;
        #1;
        release dut_a.mispredictCnt_q;
        #1;
        expectCnt(0, "cnt_preload", 32'hFFFF_FFFD);
        checkOutput();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 32'h48, 1'b1, 32'h48, 1'b0, 32'h0, 1'b1, 1'b0);
            tick();
            #1;
            expectCnt(0, "cnt_sat", satExp[i]);
            checkOutput();
        end
        idle(0, 32'h48);
        #1;
        expectLookup(0, "nt_miss_no_alloc", 1'b0, 1'b0, 32'h4C);
        checkOutput();

        // Asynchronous reset between edges, with an update in flight
        applyStimulus(0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
        tick();
        idle(0, 32'h40);
        #1;
        expectLookup(0, "pre_reset_a", 1'b1, 1'b1, 32'h100);
        expectLookup(1, "pre_reset_b", 1'b1, 1'b1, 32'h120);
        checkOutput();
        applyStimulus(0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 1'b0);
        @(posedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        expectLookup(0, "async_reset_a", 1'b0, 1'b0, 32'h44);
        expectCnt(0, "async_reset_a", 32'h0);
        expectLookup(1, "async_reset_b", 1'b0, 1'b0, 32'h44);
        expectCnt(1, "async_reset_b", 32'h0);
        checkOutput();
        @(negedge CLK);
        idle(0, 32'h40);
        nRST = 1'b1;
        tick();
        #1;
        expectLookup(0, "post_reset_a", 1'b0, 1'b0, 32'h44);
        checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
